// File: rtl/fb_vga_scanout.sv
// fb_vga_scanout
//   Display-side consumer of a 400x300 RGB444 frame buffer. Generates 640x480
//   VGA raster timing, issues one buffer read per image pixel in raster order,
//   and drives the returned colour inside a centred 400x300 window. Active
//   pixels outside the window are black, or BORDER_RGB when the
//   FB_SCANOUT_BORDER_EN macro is defined. Blanking always outputs black.
//   The raster advances one pixel per pix_ce tick.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   pix_ce       pixel-rate enable; raster, pipeline and pins hold while low
//   fb_rd_en     combinational read strobe to the frame buffer
//   fb_R/G/B     buffer read data, valid the clk after fb_rd_en
//   vga_r/g/b    registered colour
//   vga_hs/vs    registered syncs, active-low
//   frame_start  registered one-clk pulse when the pins present pixel (0,0)
//
// Configuration macro: FB_SCANOUT_BORDER_EN
module fb_vga_scanout #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          IMG_W      = 400,
    parameter int          IMG_H      = 300,
    parameter int          IMG_X0     = 120,
    parameter int          IMG_Y0     = 90,
    parameter logic [11:0] BORDER_RGB = 12'h222
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    output logic       fb_rd_en,
    input  logic [3:0] fb_R,
    input  logic [3:0] fb_G,
    input  logic [3:0] fb_B,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       frame_start
);

    localparam int CNT_W = 10;

    // Region boundaries, pre-cast to counter width so every compare is
    // same-width. Ranges are half-open [begin, end).
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] WIN_X0   = CNT_W'(IMG_X0);
    localparam logic [CNT_W-1:0] WIN_X1   = CNT_W'(IMG_X0 + IMG_W);
    localparam logic [CNT_W-1:0] WIN_Y0   = CNT_W'(IMG_Y0);
    localparam logic [CNT_W-1:0] WIN_Y1   = CNT_W'(IMG_Y0 + IMG_H);

`ifdef FB_SCANOUT_BORDER_EN
    localparam logic [11:0] FILL_RGB = BORDER_RGB;
`else
    // Border disabled: the fill colour is black and BORDER_RGB has no effect.
    localparam logic [11:0] FILL_RGB = BORDER_RGB & 12'h000;
`endif

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    // Raster counters: active region first, then front porch, sync, back
    // porch. Line and frame wrap happen on the tick of the last pixel.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Flags for the position currently being counted.
    logic win, act, hs_n, vs_n, origin;

    assign win    = (h_cnt >= WIN_X0) && (h_cnt < WIN_X1) &&
                    (v_cnt >= WIN_Y0) && (v_cnt < WIN_Y1);
    assign act    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_n   = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vs_n   = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    assign origin = (h_cnt == '0) && (v_cnt == '0);

    // Gated with reset so no read escapes on the edge that resets the raster;
    // the buffer is reset on that same edge and its pointer stays aligned.
    assign fb_rd_en = pix_ce & win & ~reset;

    // One-stage delay: the buffer answers one clk after the read, and the
    // pins update on the following tick, so flags are delayed to match.
    logic win_d, act_d, hs_d, vs_d, origin_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            win_d    <= 1'b0;
            act_d    <= 1'b0;
            hs_d     <= 1'b1;
            vs_d     <= 1'b1;
            origin_d <= 1'b0;
        end else if (pix_ce) begin
            win_d    <= win;
            act_d    <= act;
            hs_d     <= hs_n;
            vs_d     <= vs_n;
            origin_d <= origin;
        end
    end

    // Colour selection for the delayed position.
    // NOTE: the default assignment ahead of the if-chain keeps this block
    // purely combinational; without it an unassigned path infers a latch.
    logic [11:0] pix_rgb;

    always_comb begin
        pix_rgb = 12'h000;
        if (win_d) begin
            pix_rgb = {fb_R, fb_G, fb_B};
        end else if (act_d) begin
            pix_rgb = FILL_RGB;
        end
    end

    // Pin registers. frame_start is cleared on every non-tick clk so it is a
    // single-clk pulse even when pix_ce is sparse.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r       <= 4'h0;
            vga_g       <= 4'h0;
            vga_b       <= 4'h0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce & origin_d;
            if (pix_ce) begin
                {vga_r, vga_g, vga_b} <= pix_rgb;
                vga_hs                <= hs_d;
                vga_vs                <= vs_d;
            end
        end
    end

endmodule

// File: tb/tb_fb_vga_scanout.sv
// Scoreboard bench for fb_vga_scanout on a shrunken raster (28x17 total,
// 20x12 active, 8x6 window at (6,3)) so several frames fit in a short run.
// Hand-computed frame figures for this raster:
//   reads/frame 48, first read tick 3*28+6 = 90, last 8*28+13 = 237,
//   hsync-low ticks/frame 3*17 = 51, vsync-low ticks/frame 2*28 = 56,
//   frame_start pulses/frame 1.
module tb_fb_vga_scanout;

    localparam int HA = 20, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 12, VFP = 1, VSW = 2, VBP = 2;
    localparam int IW = 8, IH = 6, X0 = 6, Y0 = 3;
    localparam int HT = HA + HFP + HSW + HBP;   // 28
    localparam int VT = VA + VFP + VSW + VBP;   // 17
    localparam int FRAME_TICKS = 476;

`ifdef FB_SCANOUT_BORDER_EN
    localparam logic [11:0] FILL = 12'h222;
`else
    localparam logic [11:0] FILL = 12'h000;
`endif

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } pix_t;

    localparam pix_t BUBBLE = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_ce = 1'b0;
    logic       fb_rd_en;
    logic [3:0] fb_R = '0, fb_G = '0, fb_B = '0;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, frame_start;

    fb_vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .IMG_W(IW), .IMG_H(IH), .IMG_X0(X0), .IMG_Y0(Y0),
        .BORDER_RGB(12'h222)
    ) dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .fb_rd_en(fb_rd_en),
        .fb_R(fb_R), .fb_G(fb_G), .fb_B(fb_B),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic in_win(input int h, input int v);
        return (h >= X0) && (h < X0 + IW) && (v >= Y0) && (v < Y0 + IH);
    endfunction

    function automatic pix_t expect_px(input int h, input int v);
        pix_t p;
        p.rgb = 12'h000;
        if (in_win(h, v)) p.rgb = 12'((v - Y0) * IW + (h - X0));
        else if (h < HA && v < VA) p.rgb = FILL;
        p.hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
        p.vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
        p.fs = (h == 0) && (v == 0);
        return p;
    endfunction

    // Frame buffer model: returns pixel index (wrapping per frame) one clk
    // after a read. The strobe is sampled mid-cycle to avoid an edge race.
    logic rd_seen = 1'b0;
    int   buf_idx = 0;

    always @(negedge clk) rd_seen <= fb_rd_en;

    always @(posedge clk) begin
        if (reset) begin
            buf_idx <= 0;
        end else if (rd_seen) begin
            {fb_R, fb_G, fb_B} <= 12'(buf_idx);
            buf_idx <= (buf_idx == IW * IH - 1) ? 0 : buf_idx + 1;
        end
    end

    // Stimulus side of the scoreboard: each tick pushes the expected pin
    // state for the position being counted; reset pushes one bubble for the
    // tick that shifts the reset pipeline flags onto the pins.
    pix_t sb[$];
    int   mh = 0, mv = 0, ticks_done = 0;
    logic started = 1'b0, rst_prev = 1'b0, tick_prev = 1'b0;

    always @(posedge clk) begin
        rst_prev  <= reset;
        tick_prev <= pix_ce && !reset;
        if (reset) begin
            started <= 1'b1;
            sb.delete();
            sb.push_back(BUBBLE);
            mh <= 0;
            mv <= 0;
            ticks_done <= 0;
        end else if (pix_ce && started) begin
            sb.push_back(expect_px(mh, mv));
            ticks_done <= ticks_done + 1;
            if (mh == HT - 1) begin
                mh <= 0;
                mv <= (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh <= mh + 1;
            end
        end
    end

    // Monitor: checks the strobe every clk, pops one expectation per tick,
    // and checks that pins hold between ticks. Also gathers frame statistics.
    pix_t last_exp = BUBBLE;
    int   rd_cnt = 0, first_rd = -1, last_rd = -1;
    int   hs_low = 0, vs_low = 0, fs_cnt = 0;

    always @(negedge clk) begin
        pix_t e;
        if (started) begin
            check("fb_rd_en", 32'(fb_rd_en), 32'(pix_ce && in_win(mh, mv) && !reset));
            if (rst_prev) begin
                check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
                check("rst_hs", 32'(vga_hs), 32'(1));
                check("rst_vs", 32'(vga_vs), 32'(1));
                check("rst_fs", 32'(frame_start), 32'(0));
                last_exp <= BUBBLE;
                rd_cnt <= 0; first_rd <= -1; last_rd <= -1;
                hs_low <= 0; vs_low <= 0; fs_cnt <= 0;
            end else begin
                if (tick_prev) begin
                    if (sb.size() == 0) begin
                        check("sb_empty", 32'(0), 32'(1));
                        e = BUBBLE;
                    end else begin
                        e = sb.pop_front();
                    end
                    check("pix_rgb", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
                    check("pix_hs", 32'(vga_hs), 32'(e.hs));
                    check("pix_vs", 32'(vga_vs), 32'(e.vs));
                    check("pix_fs", 32'(frame_start), 32'(e.fs));
                    last_exp <= '{rgb: e.rgb, hs: e.hs, vs: e.vs, fs: 1'b0};
                    if (ticks_done >= 1 && ticks_done <= FRAME_TICKS + 1) begin
                        if (!vga_hs) hs_low <= hs_low + 1;
                        if (!vga_vs) vs_low <= vs_low + 1;
                    end
                end else begin
                    check("hold_rgb", 32'({vga_r, vga_g, vga_b}), 32'(last_exp.rgb));
                    check("hold_hs", 32'(vga_hs), 32'(last_exp.hs));
                    check("hold_vs", 32'(vga_vs), 32'(last_exp.vs));
                    check("hold_fs", 32'(frame_start), 32'(0));
                end
                if (fb_rd_en && ticks_done < FRAME_TICKS) begin
                    rd_cnt <= rd_cnt + 1;
                    if (first_rd < 0) first_rd <= ticks_done;
                    last_rd <= ticks_done;
                end
                if (frame_start && ticks_done <= FRAME_TICKS + 1) fs_cnt <= fs_cnt + 1;
            end
        end
    end

    // Driver helpers.
    task automatic wait_frame(input int ce_period, input string tag);
        int c = 0;
        while (ticks_done < FRAME_TICKS + 2 && c < 4000) begin
            pix_ce = ((c % ce_period) == ce_period - 1);
            @(posedge clk);
            #1;
            c++;
        end
        pix_ce = 1'b0;
        if (ticks_done < FRAME_TICKS + 2) check({tag, "_timeout"}, 32'(0), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic frame_checks(input string tag);
        check({tag, "_reads"}, 32'(rd_cnt), 32'(48));
        check({tag, "_first_rd"}, 32'(first_rd), 32'(90));
        check({tag, "_last_rd"}, 32'(last_rd), 32'(237));
        check({tag, "_hs_low"}, 32'(hs_low), 32'(51));
        check({tag, "_vs_low"}, 32'(vs_low), 32'(56));
        check({tag, "_fs_cnt"}, 32'(fs_cnt), 32'(1));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        int c;

        // Phase 1: pix_ce continuous for one frame.
        pix_ce = 1'b0;
        do_reset(2);
        wait_frame(1, "cont");
        frame_checks("cont");

        // Phase 2: pix_ce every 4th clk; counts in ticks are unchanged.
        do_reset(1);
        wait_frame(4, "ce4");
        frame_checks("ce4");

        // Phase 3: one-clk reset inside the window at (10,5), then a full frame.
        do_reset(1);
        pix_ce = 1'b1;
        c = 0;
        while (!(mh == 10 && mv == 5) && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("mid_reach", 32'(mh == 10 && mv == 5), 32'(1));
        check("mid_rd_before", 32'(fb_rd_en), 32'(1));
        reset = 1'b1;
        #1;
        check("mid_rd_in_reset", 32'(fb_rd_en), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        pix_ce = 1'b1;
        check("post_rst_rd", 32'(fb_rd_en), 32'(0));
        check("post_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
        check("post_rst_sync", 32'({vga_hs, vga_vs}), 32'b11);
        check("post_rst_fs", 32'(frame_start), 32'(0));
        wait_frame(1, "mid");
        frame_checks("mid");

        check("sb_drained", 32'(sb.size() <= 2), 32'(1));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fb_vga_scanout.md
# fb_vga_scanout

Display-side consumer of the 400x300 RGB444 frame buffer. Generates 640x480 VGA raster timing, issues exactly one buffer read per image pixel in raster order, and drives the returned colour onto the VGA pins inside a fixed, centred 400x300 window. Everything outside the window is blanked or filled with a border colour. Runs on the system clock and advances one pixel per `pix_ce` tick.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (ticks)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- IMG_W / IMG_H, 400 / 300, image window size
- IMG_X0 / IMG_Y0, 120 / 90, window top-left in active coordinates
- BORDER_RGB, 12'h222, RGB444 fill colour (used only with the macro)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pix_ce  in  1  pixel-rate enable; the raster advances only on cycles where it is high
- fb_rd_en  out  1  read strobe to the frame buffer, combinational
- fb_R / fb_G / fb_B  in  4 each  buffer read data, valid the clk after `fb_rd_en`, held until the next read
- vga_r / vga_g / vga_b  out  4 each  registered colour
- vga_hs / vga_vs  out  1 each  registered syncs, active-low
- frame_start  out  1  registered one-clk pulse marking pixel (0,0) on the pins

## Operation
- Counters:
  - `h_cnt`: 0..799; wraps to 0 on a pix_ce tick.
  - `v_cnt`: 0..524; increments when `h_cnt` wraps and itself wraps at 524→0.
  - Both hold when `pix_ce` = 0.
  - Region order: active first, then front porch, sync, back porch.
- Window: `win` = (IMG_X0 ≤ h_cnt < IMG_X0+IMG_W) and (IMG_Y0 ≤ v_cnt < IMG_Y0+IMG_H).
- Read strobe: `fb_rd_en` = `pix_ce` & `win` & ~`reset`.
  - Exactly IMG_W*IMG_H = 120000 pulses per frame, in raster order.
  - Never asserted twice for one pixel.
  - Read pointer alignment belongs to the buffer; this block neither counts addresses nor resets them.
- Pixel pipeline, one stage, updating on pix_ce ticks only:
  - Each pix_ce tick latches `win_d`, `act_d` (h < H_ACTIVE and v < V_ACTIVE), `hs_d` and `vs_d` for the current position.
  - Pin registers update on a pix_ce tick from the delayed flags and the buffer data:
    - `win_d`: output `fb_*`.
    - `act_d` & ~`win_d`: output border/black (see Configuration).
    - Otherwise: output 0.
  - `vga_hs` is low while h_cnt ∈ [656, 751]; `vga_vs` is low while v_cnt ∈ [490, 491]. Both are delayed by the same stage so they stay aligned with the colour.
- `frame_start` is 1 for exactly one clk, on the pix_ce tick where the pins present position (0,0).

## Timing
- Reset values: h_cnt = v_cnt = 0; all colour outputs 0; vga_hs = vga_vs = 1; frame_start = 0; fb_rd_en = 0.
- Latency: a position's colour, syncs and frame_start reach the pins on the pix_ce tick after the tick that position was counted.
  - Buffer data returned 1 clk after `fb_rd_en` is therefore always sampled, for any pix_ce spacing ≥ 1 clk.
- `pix_ce` held high continuously: one pixel per clk; the frame period is 800*525 = 420000 clk.
- `pix_ce` low: counters, pipeline and pins all hold; no reads are issued.
- Reset mid-frame: all state returns to reset values on the next edge, and the next frame starts at (0,0). The buffer must be reset in the same cycle to keep its pointer aligned.
- Line wrap and frame wrap occur on the same tick as the last pixel's advance; no dead cycles are inserted.

## Configuration
- `FB_SCANOUT_BORDER_EN`:
  - Defined: active pixels outside the window output BORDER_RGB (r = [11:8], g = [7:4], b = [3:0]).
  - Undefined: those pixels output 0, and the BORDER_RGB parameter is unused.
- Blanking intervals output 0 in both cases.

## Test plan
- Reset, `pix_ce` = 1 for one frame → 120000 `fb_rd_en` pulses; the first occurs at h = 120, v = 90, the last at h = 519, v = 389.
- Same run, sync timing:
  - `vga_hs` low for 96 clk every 800 clk.
  - `vga_vs` low for 1600 clk every 420000 clk.
  - `frame_start` pulses once per 420000 clk.
- Buffer model returns RGB = pixel index[11:0] → pins show the same value exactly one pix_ce tick after the corresponding `fb_rd_en`; (0,0) of the window shows 0x000 and (1,0) shows 0x001.
- `pix_ce` every 4th clk → same pulse counts and sync widths in ticks; no read is issued on a non-CE clk; outputs are stable between ticks.
- Pixel (0,0), i.e. outside the window → 0x222 with `FB_SCANOUT_BORDER_EN` defined, 0x000 without it; blanking outputs 0x000 in both builds.
- Assert `reset` for 1 clk at h = 300, v = 200:
  - Next clk: outputs at reset values, `fb_rd_en` = 0.
  - Raster restarts at (0,0).
  - Full frame count of 120000 reads is reached again.
